// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between a CPU load/store port (req/done handshake) and a block-wide
// main memory; misses write back a dirty victim and then refill the line.
module dm_cache_ctrl #(
    parameter int MEM_LATENCY = 2,
    parameter int NUM_LINES   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpuReq,
    input  logic         cpuWrite,
    input  logic [9:0]   cpuAddr,
    input  logic [31:0]  cpuWriteData,
    output logic [31:0]  cpuReadData,
    output logic         cpuDone,
    output logic         memReadWrite,
    output logic [9:0]   memAddr,
    output logic [127:0] memWriteData,
    input  logic [127:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } StateT;

    StateT state;
    StateT nextState;

    logic [NUM_LINES-1:0] lineValid;
    logic [NUM_LINES-1:0] lineDirty;
    logic [3:0]           lineTag  [NUM_LINES];
    logic [127:0]         lineData [NUM_LINES];

    logic        reqWrite;
    logic [9:0]  reqAddr;
    logic [31:0] reqWriteData;
    logic [3:0]  counter;

    logic [1:0]  reqWord;
    logic [1:0]  reqIdx;
    logic [3:0]  reqTag;
    logic        hit;
    logic        accept;
    logic        victimDirty;

    assign reqWord     = reqAddr[3:2];
    assign reqIdx      = reqAddr[5:4];
    assign reqTag      = reqAddr[9:6];
    assign hit         = lineValid[reqIdx] && (lineTag[reqIdx] == reqTag);
    assign victimDirty = lineValid[reqIdx] && lineDirty[reqIdx];
    assign accept      = cpuReq && !cpuDone;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decisions: lookup, optional writeback, then refill and re-lookup.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    nextState = IDLE;
                end else if (victimDirty) begin
                    nextState = WRITEBACK;
                end else begin
                    nextState = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (counter == 4'd0) begin
                    nextState = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (counter == 4'd0) begin
                    nextState = COMPARE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: request latch, line storage, CPU response and memory bus drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lineValid    <= '0;
            lineDirty    <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                lineTag[i]  <= '0;
                lineData[i] <= '0;
            end
            reqWrite     <= 1'b0;
            reqAddr      <= '0;
            reqWriteData <= '0;
            counter      <= '0;
            cpuDone      <= 1'b0;
            cpuReadData  <= '0;
            memReadWrite <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
        end else begin
            cpuDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqWrite     <= cpuWrite;
                        reqAddr      <= cpuAddr;
                        reqWriteData <= cpuWriteData;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (reqWrite) begin
                            lineData[reqIdx][{reqWord, 5'b0} +: 32] <= reqWriteData;
                            lineDirty[reqIdx] <= 1'b1;
                        end else begin
                            cpuReadData <= lineData[reqIdx][{reqWord, 5'b0} +: 32];
                        end
                        cpuDone <= 1'b1;
                    end else if (victimDirty) begin
                        memReadWrite <= 1'b1;
                        memAddr      <= {lineTag[reqIdx], reqIdx, 4'b0};
                        memWriteData <= lineData[reqIdx];
                        counter      <= 4'(MEM_LATENCY - 1);
                    end else begin
                        memReadWrite <= 1'b0;
                        memAddr      <= {reqTag, reqIdx, 4'b0};
                        counter      <= 4'(MEM_LATENCY - 1);
                    end
                end
                WRITEBACK: begin
                    if (counter == 4'd0) begin
                        memReadWrite <= 1'b0;
                        memAddr      <= {reqTag, reqIdx, 4'b0};
                        counter      <= 4'(MEM_LATENCY - 1);
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                ALLOCATE: begin
                    if (counter == 4'd0) begin
                        lineData[reqIdx]  <= memReadData;
                        lineValid[reqIdx] <= 1'b1;
                        lineDirty[reqIdx] <= 1'b0;
                        lineTag[reqIdx]   <= reqTag;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: begin
                    memReadWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule
